imem_load_ctrl: RTL and testbench
=================================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of instruction words held.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter OOR_WORD, default 32'h00000000, meaning word returned for out-of-range fetch.
REQ-004 SHALL have Clk  input  1  sole clock, rising edge.
REQ-005 SHALL have Rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have FetchReq  input  1  CPU fetch request.
REQ-007 SHALL have FetchAddr  input  32  CPU word address (PC).
REQ-008 SHALL have FetchValid  output  1  FetchData valid this cycle.
REQ-009 SHALL have FetchData  output  DATA_W  fetched instruction.
REQ-010 SHALL have CpuHold  output  1  CPU must stall PC while high.
REQ-011 SHALL have LoadStart  input  1  begin program load.
REQ-012 SHALL have LoadValid  input  1  load beat valid.
REQ-013 SHALL have LoadData  input  DATA_W  load beat instruction word.
REQ-014 SHALL have LoadLast  input  1  final beat of program.
REQ-015 SHALL have LoadReady  output  1  controller accepts load beat.
REQ-016 SHALL have LoadDone  output  1  one-cycle pulse at load completion.
REQ-017 SHALL have LoadErr  output  1  sticky overflow flag.
REQ-018 SHALL have LoadCount  output  6  words written by most recent load.

Function
REQ-019 SHALL implement FSM states RUN, LOAD, FLUSH; reset state RUN.
REQ-020 In RUN, FetchReq SHALL be accepted every cycle; FetchValid SHALL assert exactly one cycle later with FetchData = mem[FetchAddr] (registered read, latency 1).
REQ-021 FetchAddr >= DEPTH SHALL return OOR_WORD with FetchValid asserted normally.
REQ-022 RUN -> LOAD when LoadStart=1; a FetchReq in the same cycle SHALL still complete next cycle with pre-load contents.
REQ-023 Entering LOAD SHALL clear write pointer WrPtr to 0, clear LoadErr, clear LoadCount.
REQ-024 In LOAD: LoadReady=1, CpuHold=1, FetchReq ignored, FetchValid=0.
REQ-025 Beat accepted when LoadValid&LoadReady; mem[WrPtr] <= LoadData, WrPtr and LoadCount increment.
REQ-026 Accepted beat with LoadLast=1 SHALL move LOAD -> FLUSH.
REQ-027 Accepted beat at WrPtr = DEPTH-1 without LoadLast SHALL write the word, set LoadErr, move to FLUSH; subsequent beats not accepted.
REQ-028 LoadStart during LOAD or FLUSH SHALL be ignored.
REQ-029 FLUSH lasts exactly one cycle: CpuHold=1, LoadReady=0, LoadDone=1, FetchValid=0; then RUN.
REQ-030 CpuHold SHALL be 0 in RUN; LoadReady SHALL be 0 outside LOAD.
REQ-031 LoadCount SHALL saturate at DEPTH and hold value until next LOAD entry.
REQ-032 Memory contents SHALL persist across loads except written locations.

Reset
REQ-033 Rst_n low SHALL immediately force state RUN, FetchValid=0, FetchData=0, CpuHold=0, LoadReady=0, LoadDone=0, LoadErr=0, LoadCount=0, WrPtr=0.
REQ-034 Memory array SHALL NOT be reset; reset mid-load leaves partially written contents.
REQ-035 First fetch SHALL be accepted on the first rising edge after Rst_n deasserts.

Structure
REQ-036 FSM state encoding and OOR_WORD default SHALL reside in shared package imem_pkg.
REQ-037 Storage SHALL be sub-module imem_ram (1 write port, 1 registered read port, DEPTH x DATA_W); controller contains FSM, pointer, counters.

Verification
REQ-038 Load 10 words 0x0000008e..0x00000012 with LoadLast on beat 10 -> LoadCount=10, LoadDone pulse one cycle after beat 10, LoadErr=0; fetch addr 9 -> 0x00000012 one cycle later.
REQ-039 FetchReq addr 40 in RUN -> FetchValid next cycle, FetchData=0x00000000.
REQ-040 FetchReq addr 2 and LoadStart same cycle, first beat writes 0xDEADBEEF to addr 0 -> FetchValid next cycle with old mem[2]; CpuHold=1 from next cycle until FLUSH ends.
REQ-041 Stream 33 beats without LoadLast -> 32 words written, LoadErr=1, LoadReady=0 after beat 32, LoadCount=32; next LoadStart clears LoadErr.
REQ-042 Assert Rst_n low after 5 load beats -> all outputs at reset values asynchronously, state RUN, words 0..4 retain new data.
REQ-043 LoadValid toggling 1/0 each cycle during load of 4 words -> exactly 4 writes, WrPtr increments only on valid beats.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory load controller:
// controller state encoding, default out-of-range word, counter helpers.
package imem_pkg;

  // Controller states (plain constants so legacy tools can consume them)
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Word handed back when the CPU fetches beyond the populated memory
  localparam logic [31:0] OOR_WORD_DEFAULT = 32'h0000_0000;

  // Width of the externally visible load counter
  localparam int COUNT_W = 6;

  // Increment that sticks at the given limit instead of wrapping
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value,
                                                 input logic [COUNT_W-1:0] limit);
    return (value < limit) ? value + COUNT_W'(1) : value;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port, one registered read port.
// Deliberately has no reset so a reset in the middle of a load leaves
// whatever was already written in place.
module imem_ram #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read data only changes when a read is requested
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Storage write and read-data register
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction memory with a program-load path. In RUN the CPU fetches
// with one cycle of latency; a load stalls the CPU, streams words into
// memory from address 0, then spends one FLUSH cycle before returning.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int                 DEPTH    = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  OOR_WORD = DATA_W'(OOR_WORD_DEFAULT)
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                FetchReq,
  input  logic [31:0]         FetchAddr,
  output logic                FetchValid,
  output logic [DATA_W-1:0]   FetchData,
  output logic                CpuHold,
  input  logic                LoadStart,
  input  logic                LoadValid,
  input  logic [DATA_W-1:0]   LoadData,
  input  logic                LoadLast,
  output logic                LoadReady,
  output logic                LoadDone,
  output logic                LoadErr,
  output logic [COUNT_W-1:0]  LoadCount
);

  localparam int                 AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]      LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEPTH);

  logic [1:0]          state_q,       state_d;
  logic [AW-1:0]       wr_ptr_q,      wr_ptr_d;
  logic [COUNT_W-1:0]  load_count_q,  load_count_d;
  logic                load_err_q,    load_err_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                oor_q,         oor_d;

  logic                in_range;
  logic                ram_we;
  logic                ram_re;
  logic [DATA_W-1:0]   ram_rdata;

  // Whole 32-bit address is compared so high garbage bits count as out of range
  assign in_range = (FetchAddr < 32'(DEPTH));

  // Next-state logic for the FSM, write pointer, counters and fetch pipeline
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    load_count_d  = load_count_q;
    load_err_d    = load_err_q;
    fetch_valid_d = 1'b0;
    oor_d         = oor_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A fetch issued alongside LoadStart still completes from old contents
        if (FetchReq) begin
          fetch_valid_d = 1'b1;
          oor_d         = ~in_range;
          ram_re        = in_range;
        end
        if (LoadStart) begin
          state_d      = ST_LOAD;
          wr_ptr_d     = '0;
          load_count_d = '0;
          load_err_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        if (LoadValid) begin
          ram_we       = 1'b1;
          load_count_d = sat_inc(load_count_q, COUNT_MAX);
          if (LoadLast) begin
            state_d = ST_FLUSH;
          end else if (wr_ptr_q == LAST_PTR) begin
            // Memory is full and the host still has more: flag and stop
            load_err_d = 1'b1;
            state_d    = ST_FLUSH;
          end
          if (wr_ptr_q != LAST_PTR) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end

      ST_FLUSH: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Controller registers; memory contents are not part of this reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      load_count_q  <= '0;
      load_err_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      oor_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      load_count_q  <= load_count_d;
      load_err_q    <= load_err_d;
      fetch_valid_q <= fetch_valid_d;
      oor_q         <= oor_d;
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (LoadData),
    .re    (ram_re),
    .raddr (FetchAddr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Fetch data is forced to zero whenever no fetch result is being presented
  assign FetchValid = fetch_valid_q;
  assign FetchData  = !fetch_valid_q ? '0 :
                      oor_q          ? OOR_WORD : ram_rdata;

  assign CpuHold    = (state_q != ST_RUN);
  assign LoadReady  = (state_q == ST_LOAD);
  assign LoadDone   = (state_q == ST_FLUSH);
  assign LoadErr    = load_err_q;
  assign LoadCount  = load_count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed loads, a fetch vector
// table, reset-during-load, and randomized loads/fetches against a model.
module tb_imem_load_ctrl;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } fetch_vec_t;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b1;
  logic              FetchReq = 1'b0;
  logic [31:0]       FetchAddr = '0;
  logic              LoadStart = 1'b0;
  logic              LoadValid = 1'b0;
  logic [DATA_W-1:0] LoadData = '0;
  logic              LoadLast = 1'b0;
  logic              FetchValid;
  logic [DATA_W-1:0] FetchData;
  logic              CpuHold;
  logic              LoadReady;
  logic              LoadDone;
  logic              LoadErr;
  logic [5:0]        LoadCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelMem   [DEPTH];
  bit          modelKnown [DEPTH];

  imem_load_ctrl #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .OOR_WORD (32'h0000_0000)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .FetchReq   (FetchReq),
    .FetchAddr  (FetchAddr),
    .FetchValid (FetchValid),
    .FetchData  (FetchData),
    .CpuHold    (CpuHold),
    .LoadStart  (LoadStart),
    .LoadValid  (LoadValid),
    .LoadData   (LoadData),
    .LoadLast   (LoadLast),
    .LoadReady  (LoadReady),
    .LoadDone   (LoadDone),
    .LoadErr    (LoadErr),
    .LoadCount  (LoadCount)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  // Watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] refFetch(input logic [31:0] a);
    if (a >= DEPTH) return 32'h0000_0000;
    return modelMem[a[4:0]];
  endfunction

  function automatic bit refKnown(input logic [31:0] a);
    if (a >= DEPTH) return 1'b1;
    return modelKnown[a[4:0]];
  endfunction

  task automatic doFetch(input logic [31:0] addr, input string name);
    FetchReq  = 1'b1;
    FetchAddr = addr;
    applyStimulus();
    FetchReq = 1'b0;
    checkOutput({name, " valid"}, 32'(FetchValid), 32'd1);
    checkOutput({name, " data"}, FetchData, refFetch(addr));
  endtask

  // One whole load: a program of n words either ends with LoadLast or
  // overflows after DEPTH words; gappy inserts an idle cycle after each beat.
  task automatic loadProgram(input logic [31:0] words[$], input bit withLast,
                             input bit gappy, input int fetchAddr, input string name);
    int          n;
    int          expCount;
    bit          expErr;
    logic [31:0] oldData;
    n        = words.size();
    expCount = (n <= DEPTH) ? n : DEPTH;
    expErr   = (n > DEPTH);
    oldData  = '0;
    LoadStart = 1'b1;
    if (fetchAddr >= 0) begin
      FetchReq  = 1'b1;
      FetchAddr = 32'(fetchAddr);
      oldData   = refFetch(32'(fetchAddr));
    end
    applyStimulus();
    LoadStart = 1'b0;
    FetchReq  = 1'b0;
    checkOutput({name, " start FetchValid"}, 32'(FetchValid), (fetchAddr >= 0) ? 32'd1 : 32'd0);
    if (fetchAddr >= 0) checkOutput({name, " start FetchData"}, FetchData, oldData);
    checkOutput({name, " start CpuHold"}, 32'(CpuHold), 32'd1);
    checkOutput({name, " start LoadReady"}, 32'(LoadReady), 32'd1);
    checkOutput({name, " start LoadCount"}, 32'(LoadCount), 32'd0);
    checkOutput({name, " start LoadErr"}, 32'(LoadErr), 32'd0);
    for (int i = 0; i < expCount; i++) begin
      LoadValid = 1'b1;
      LoadData  = words[i];
      LoadLast  = withLast && (i == n - 1);
      applyStimulus();
      modelMem[i]   = words[i];
      modelKnown[i] = 1'b1;
      LoadValid = 1'b0;
      LoadLast  = 1'b0;
      if (i + 1 < expCount) begin
        checkOutput({name, " beat LoadCount"}, 32'(LoadCount), 32'(i + 1));
        if (gappy) begin
          FetchReq  = 1'b1;
          FetchAddr = 32'd0;
          applyStimulus();
          FetchReq = 1'b0;
          checkOutput({name, " gap LoadCount"}, 32'(LoadCount), 32'(i + 1));
          checkOutput({name, " gap FetchValid"}, 32'(FetchValid), 32'd0);
          checkOutput({name, " gap LoadReady"}, 32'(LoadReady), 32'd1);
        end
      end
    end
    // FLUSH cycle: an extra offered beat here must not be taken
    LoadValid = (n > expCount);
    LoadData  = 32'hBADB_AD00;
    checkOutput({name, " flush LoadDone"}, 32'(LoadDone), 32'd1);
    checkOutput({name, " flush LoadReady"}, 32'(LoadReady), 32'd0);
    checkOutput({name, " flush CpuHold"}, 32'(CpuHold), 32'd1);
    checkOutput({name, " flush FetchValid"}, 32'(FetchValid), 32'd0);
    checkOutput({name, " flush LoadCount"}, 32'(LoadCount), 32'(expCount));
    checkOutput({name, " flush LoadErr"}, 32'(LoadErr), 32'(expErr));
    applyStimulus();
    LoadValid = 1'b0;
    checkOutput({name, " run LoadDone"}, 32'(LoadDone), 32'd0);
    checkOutput({name, " run CpuHold"}, 32'(CpuHold), 32'd0);
    checkOutput({name, " run LoadReady"}, 32'(LoadReady), 32'd0);
    checkOutput({name, " run LoadCount"}, 32'(LoadCount), 32'(expCount));
    checkOutput({name, " run LoadErr"}, 32'(LoadErr), 32'(expErr));
  endtask

  // Main test sequence
  initial begin
    fetch_vec_t  vecs [7];
    logic [31:0] prog [$];
    logic [31:0] newWords [5];
    int          n;

    for (int i = 0; i < DEPTH; i++) begin
      modelMem[i]   = '0;
      modelKnown[i] = 1'b0;
    end

    // Reset state, observed while reset is held
    #2 Rst_n = 1'b0;
    #1;
    checkOutput("reset FetchValid", 32'(FetchValid), 32'd0);
    checkOutput("reset FetchData", FetchData, 32'd0);
    checkOutput("reset CpuHold", 32'(CpuHold), 32'd0);
    checkOutput("reset LoadReady", 32'(LoadReady), 32'd0);
    checkOutput("reset LoadDone", 32'(LoadDone), 32'd0);
    checkOutput("reset LoadErr", 32'(LoadErr), 32'd0);
    checkOutput("reset LoadCount", 32'(LoadCount), 32'd0);
    applyStimulus();
    applyStimulus();
    Rst_n = 1'b1;

    // First edge after reset accepts a fetch; out-of-range returns the OOR word
    doFetch(32'd40, "first fetch oor");

    // Ten-word program with LoadLast on the tenth beat
    prog = '{32'h8e, 32'h7d, 32'h6c, 32'h5b, 32'h4a, 32'h39, 32'h28, 32'h17, 32'h15, 32'h12};
    loadProgram(prog, 1'b1, 1'b0, -1, "load10");
    doFetch(32'd9, "load10 addr9");

    // Table of fetch vectors against the ten-word image
    vecs[0] = '{addr: 32'd0,          data: 32'h0000_008e, name: "vec addr0"};
    vecs[1] = '{addr: 32'd3,          data: 32'h0000_005b, name: "vec addr3"};
    vecs[2] = '{addr: 32'd9,          data: 32'h0000_0012, name: "vec addr9"};
    vecs[3] = '{addr: 32'd32,         data: 32'h0000_0000, name: "vec addr32"};
    vecs[4] = '{addr: 32'd40,         data: 32'h0000_0000, name: "vec addr40"};
    vecs[5] = '{addr: 32'hFFFF_FFFF,  data: 32'h0000_0000, name: "vec addrmax"};
    vecs[6] = '{addr: 32'h0000_0105,  data: 32'h0000_0000, name: "vec alias5"};
    for (int i = 0; i < 7; i++) begin
      FetchReq  = 1'b1;
      FetchAddr = vecs[i].addr;
      applyStimulus();
      FetchReq = 1'b0;
      checkOutput({vecs[i].name, " valid"}, 32'(FetchValid), 32'd1);
      checkOutput({vecs[i].name, " data"}, FetchData, vecs[i].data);
    end

    // Fetch of addr 2 in the same cycle as LoadStart sees pre-load data
    prog = '{32'hDEAD_BEEF};
    loadProgram(prog, 1'b1, 1'b0, 2, "fetch+start");
    doFetch(32'd0, "after deadbeef addr0");
    doFetch(32'd2, "after deadbeef addr2");

    // Four words with LoadValid toggling every cycle
    prog = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    loadProgram(prog, 1'b1, 1'b1, -1, "toggle4");
    doFetch(32'd3, "toggle4 addr3");
    doFetch(32'd4, "toggle4 addr4 persists");

    // Exactly DEPTH words ending with LoadLast: full but no error
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    loadProgram(prog, 1'b1, 1'b0, -1, "full32");
    doFetch(32'd31, "full32 addr31");

    // 33 beats with no LoadLast: overflow
    prog.delete();
    for (int i = 0; i < DEPTH + 1; i++) prog.push_back(32'hA500_0000 | 32'(i));
    loadProgram(prog, 1'b0, 1'b0, -1, "overflow");
    doFetch(32'd31, "overflow addr31");
    doFetch(32'd0, "overflow addr0");

    // Next load clears the sticky error (checked at load entry)
    prog = '{32'h0BAD_F00D, 32'hFEED_0001};
    loadProgram(prog, 1'b1, 1'b0, -1, "after overflow");

    // Reset asserted after five beats of a load
    LoadStart = 1'b1;
    applyStimulus();
    LoadStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      newWords[i] = 32'hC0DE_0000 | 32'(i);
      LoadValid = 1'b1;
      LoadData  = newWords[i];
      applyStimulus();
      modelMem[i]   = newWords[i];
      modelKnown[i] = 1'b1;
    end
    checkOutput("midload LoadCount", 32'(LoadCount), 32'd5);
    Rst_n = 1'b0;
    #1;
    checkOutput("midreset CpuHold", 32'(CpuHold), 32'd0);
    checkOutput("midreset LoadReady", 32'(LoadReady), 32'd0);
    checkOutput("midreset LoadCount", 32'(LoadCount), 32'd0);
    checkOutput("midreset LoadDone", 32'(LoadDone), 32'd0);
    checkOutput("midreset FetchValid", 32'(FetchValid), 32'd0);
    LoadValid = 1'b0;
    applyStimulus();
    Rst_n = 1'b1;
    for (int i = 0; i < 6; i++) doFetch(32'(i), "after midreset");

    // Randomized loads checked against the memory model
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, DEPTH + 6);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      loadProgram(prog, (n <= DEPTH) || ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 1) == 1, -1, "random load");
    end

    // Back-to-back random fetches, one result per issuing cycle
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      bit          r;
      r = ($urandom_range(0, 1) == 1);
      a = 32'($urandom_range(0, 47));
      if (!refKnown(a)) a = a + DEPTH;
      FetchReq  = r;
      FetchAddr = a;
      applyStimulus();
      FetchReq = 1'b0;
      checkOutput("random fetch valid", 32'(FetchValid), 32'(r));
      if (r) checkOutput("random fetch data", FetchData, refFetch(a));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
